// File: rtl/vid_pkg.sv
// Shared types and constants for the AXI4-Stream video test-pattern source.
// Pixel format is 24-bit {R,G,B}.
package vid_pkg;

    localparam int PIX_W = 24;

    typedef enum logic [1:0] {
        BARS    = 2'd0,
        RAMP    = 2'd1,
        CHECKER = 2'd2,
        SOLID   = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } tpg_state_e;

    localparam logic [PIX_W-1:0] C_WHITE   = 24'hFFFFFF;
    localparam logic [PIX_W-1:0] C_YELLOW  = 24'hFFFF00;
    localparam logic [PIX_W-1:0] C_CYAN    = 24'h00FFFF;
    localparam logic [PIX_W-1:0] C_GREEN   = 24'h00FF00;
    localparam logic [PIX_W-1:0] C_MAGENTA = 24'hFF00FF;
    localparam logic [PIX_W-1:0] C_RED     = 24'hFF0000;
    localparam logic [PIX_W-1:0] C_BLUE    = 24'h0000FF;
    localparam logic [PIX_W-1:0] C_BLACK   = 24'h000000;

    function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
        logic [PIX_W-1:0] c;
        unique case (idx)
            3'd0: c = C_WHITE;
            3'd1: c = C_YELLOW;
            3'd2: c = C_CYAN;
            3'd3: c = C_GREEN;
            3'd4: c = C_MAGENTA;
            3'd5: c = C_RED;
            3'd6: c = C_BLUE;
            default: c = C_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tpg_pixel_gen.sv
// Combinational pattern generator: (pattern, x, y, bar index, solid colour)
// mapped to one 24-bit RGB pixel.
module tpg_pixel_gen
    import vid_pkg::*;
(
    input  pattern_e         pattern_i,
    input  logic [15:0]      x_i,
    input  logic [15:0]      y_i,
    input  logic [2:0]       bar_i,
    input  logic [PIX_W-1:0] solid_i,
    output logic [PIX_W-1:0] rgb_o
);

    always_comb begin
        rgb_o = '0;
        unique case (pattern_i)
            BARS:    rgb_o = bar_color(bar_i);
            RAMP:    rgb_o = {3{x_i[7:0]}};
            CHECKER: rgb_o = (x_i[5] ^ y_i[5]) ? C_BLACK : C_WHITE;
            SOLID:   rgb_o = solid_i;
            default: rgb_o = '0;
        endcase
    end

endmodule

// File: rtl/axis_video_tpg.sv
// AXI4-Stream raster test-pattern source with frame gap and backpressure.
// Configuration is latched only at frame start; all outputs are registered.
module axis_video_tpg
    import vid_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int FRAME_GAP = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             enable,
    input  logic [1:0]       pattern_sel,
    input  logic [PIX_W-1:0] solid_rgb,
    output logic [PIX_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic             frame_done
);

    localparam int XW       = $clog2(H_ACTIVE);
    localparam int YW       = $clog2(V_ACTIVE);
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int GW       = $clog2(FRAME_GAP + 1) + 1;
    localparam int GAP_LAST = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic [GW-1:0] G_LAST   = GW'(GAP_LAST);

    tpg_state_e       state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [2:0]       bar_q, bar_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    pattern_e         pat_q, pat_d;
    logic [PIX_W-1:0] solid_q, solid_d;
    logic [PIX_W-1:0] tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tuser_q, tuser_d;
    logic             tlast_q, tlast_d;
    logic             busy_q, busy_d;
    logic             fdone_q, fdone_d;
    logic             load;
    logic             start;
    logic [PIX_W-1:0] pix;

    wire hs = tvalid_q & m_axis_tready;

    // Counter and FSM next-state; "load" marks a new pixel to present.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        bar_d    = bar_q;
        bcnt_d   = bcnt_q;
        gap_d    = gap_q;
        pat_d    = pat_q;
        solid_d  = solid_q;
        tvalid_d = tvalid_q;
        fdone_d  = 1'b0;
        load     = 1'b0;
        start    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) start = 1'b1;
            end
            ST_ACTIVE: begin
                if (hs) begin
                    if (x_q == X_LAST) begin
                        x_d    = '0;
                        bar_d  = '0;
                        bcnt_d = '0;
                        if (y_q == Y_LAST) begin
                            fdone_d = 1'b1;
                            tvalid_d = 1'b0;
                            if (FRAME_GAP == 0) begin
                                if (enable) start = 1'b1;
                                else state_d = ST_IDLE;
                            end else begin
                                state_d = ST_GAP;
                                gap_d   = '0;
                            end
                        end else begin
                            y_d  = y_q + 1'b1;
                            load = 1'b1;
                        end
                    end else begin
                        x_d  = x_q + 1'b1;
                        load = 1'b1;
                        if (bcnt_q == BAR_LAST) begin
                            bcnt_d = '0;
                            bar_d  = bar_q + 1'b1;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == G_LAST) begin
                    if (enable) start = 1'b1;
                    else state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            pat_d    = pattern_e'(pattern_sel);
            solid_d  = solid_rgb;
            x_d      = '0;
            y_d      = '0;
            bar_d    = '0;
            bcnt_d   = '0;
            state_d  = ST_ACTIVE;
            tvalid_d = 1'b1;
            load     = 1'b1;
        end
    end

    tpg_pixel_gen u_pix (
        .pattern_i (pat_d),
        .x_i       (16'(x_d)),
        .y_i       (16'(y_d)),
        .bar_i     (bar_d),
        .solid_i   (solid_d),
        .rgb_o     (pix)
    );

    always_comb begin
        tdata_d = tdata_q;
        tuser_d = tuser_q;
        tlast_d = tlast_q;
        busy_d  = (state_d != ST_IDLE);
        if (load) begin
            tdata_d = pix;
            tuser_d = (x_d == '0) && (y_d == '0);
            tlast_d = (x_d == X_LAST);
        end else if (!tvalid_d) begin
            tuser_d = 1'b0;
            tlast_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            bar_q    <= '0;
            bcnt_q   <= '0;
            gap_q    <= '0;
            pat_q    <= BARS;
            solid_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            bar_q    <= bar_d;
            bcnt_q   <= bcnt_d;
            gap_q    <= gap_d;
            pat_q    <= pat_d;
            solid_q  <= solid_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            fdone_q  <= fdone_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign frame_done    = fdone_q;

endmodule

// File: tb/tb_axis_video_tpg.sv
// Scoreboard bench for axis_video_tpg: 16x4 frames with gap 3, plus a
// 64x64 instance for the checkerboard corners.
module tb_axis_video_tpg;

    localparam int H = 16;
    localparam int V = 4;
    localparam int G = 3;
    localparam int H2 = 64;
    localparam int V2 = 64;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic        tready = 1'b1;
    logic [23:0] tdata;
    logic        tvalid, tuser, tlast, busy, fdone;

    logic        en2 = 1'b0;
    logic        tready2 = 1'b1;
    logic [23:0] tdata2;
    logic        tvalid2, tuser2, tlast2, busy2, fdone2;

    int tests = 0;
    int fails = 0;
    beat_t exp_q[$];
    int beat_cnt = 0;
    int fd_cnt = 0;
    int idle_run = 0;
    int last_gap = -1;
    bit rnd_ready = 1'b0;
    bit stall_prev = 1'b0;
    bit rst_prev = 1'b0;
    bit fd_prev = 1'b0;
    beat_t held;

    always #5 clk = ~clk;

    axis_video_tpg #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_GAP(G)) dut (
        .aclk(clk), .areset(areset), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tuser(tuser),
        .m_axis_tlast(tlast), .busy(busy), .frame_done(fdone)
    );

    axis_video_tpg #(.H_ACTIVE(H2), .V_ACTIVE(V2), .FRAME_GAP(G)) dut2 (
        .aclk(clk), .areset(areset), .enable(en2),
        .pattern_sel(2'd2), .solid_rgb(24'h0),
        .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2),
        .m_axis_tready(tready2), .m_axis_tuser(tuser2),
        .m_axis_tlast(tlast2), .busy(busy2), .frame_done(fdone2)
    );

    function automatic logic [23:0] ref_pix(int pat, int x, int y,
                                            logic [23:0] s, int h);
        logic [31:0] xv;
        xv = x;
        case (pat)
            0: case (x / (h / 8))
                0: return 24'hFFFFFF;
                1: return 24'hFFFF00;
                2: return 24'h00FFFF;
                3: return 24'h00FF00;
                4: return 24'hFF00FF;
                5: return 24'hFF0000;
                6: return 24'h0000FF;
                default: return 24'h000000;
            endcase
            1: return {xv[7:0], xv[7:0], xv[7:0]};
            2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'h0 : 24'hFFFFFF;
            default: return s;
        endcase
    endfunction

    task automatic push_frame(input int pat, input logic [23:0] s);
        beat_t b;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                b.d = ref_pix(pat, x, y, s, H);
                b.u = (x == 0) && (y == 0);
                b.l = (x == H - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // One clock: scoreboard/monitor at the negedge, return 1 after posedge.
    task automatic tick();
        beat_t got, e;
        @(negedge clk);
        got = '{d: tdata, u: tuser, l: tlast};
        if (stall_prev && !areset && !rst_prev) begin
            tests++;
            if (!tvalid || got !== held) begin
                fails++;
                $display("FAIL hold: got v=%0b %h/%0b/%0b required v=1 %h/%0b/%0b",
                         tvalid, got.d, got.u, got.l, held.d, held.u, held.l);
            end
        end
        if (fdone) begin
            fd_cnt++;
            tests++;
            if (fd_prev) begin
                fails++;
                $display("FAIL frame_done_width: got 2+ cycles required 1");
            end
        end
        if (tvalid) begin
            if (tuser) last_gap = idle_run;
            idle_run = 0;
        end else begin
            idle_run++;
        end
        if (tvalid && tready) begin
            beat_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected: got %h required none", got.d);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL beat%0d: got %h/%0b/%0b required %h/%0b/%0b",
                             beat_cnt - 1, got.d, got.u, got.l, e.d, e.u, e.l);
                end
            end
        end
        stall_prev = tvalid && !tready;
        held = got;
        rst_prev = areset;
        fd_prev = fdone;
        @(posedge clk);
        #1;
        if (rnd_ready) tready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_fd(input int budget, input string name);
        int f0, n;
        f0 = fd_cnt;
        n = 0;
        while (fd_cnt == f0 && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (fd_cnt == f0) begin
            fails++;
            $display("FAIL %s_timeout: got no frame_done required pulse", name);
        end
    endtask

    task automatic wait_beats(input int n, input string name);
        int b0, c;
        b0 = beat_cnt;
        c = 0;
        while (beat_cnt - b0 < n && c < 1000) begin
            tick();
            c++;
        end
        tests++;
        if (beat_cnt - b0 < n) begin
            fails++;
            $display("FAIL %s_beats: got %0d required %0d", name, beat_cnt - b0, n);
        end
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        while (!tvalid && c < 50) begin
            tick();
            c++;
        end
        tests++;
        if (!tvalid) begin
            fails++;
            $display("FAIL %s_restart: got tvalid=0 required 1", name);
        end
    endtask

    task automatic check_drained(input string name);
        repeat (8) tick();
        tests++;
        if (exp_q.size() != 0 || busy !== 1'b0 || tvalid !== 1'b0) begin
            fails++;
            $display("FAIL %s_drain: got left=%0d busy=%0b v=%0b required 0/0/0",
                     name, exp_q.size(), busy, tvalid);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) tick();
        tests++;
        if (tvalid !== 1'b0 || tdata !== 24'h0 || tuser !== 1'b0 ||
            tlast !== 1'b0 || busy !== 1'b0 || fdone !== 1'b0) begin
            fails++;
            $display("FAIL reset: got v%0b d%h u%0b l%0b b%0b f%0b required all 0",
                     tvalid, tdata, tuser, tlast, busy, fdone);
        end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_bars();
        int vcyc, f0, c;
        pattern_sel = 2'd0;
        push_frame(0, 24'h0);
        enable = 1'b1;
        vcyc = 0;
        f0 = fd_cnt;
        c = 0;
        while (fd_cnt == f0 && c < 500) begin
            tick();
            if (tvalid) vcyc++;
            c++;
        end
        tests++;
        if (vcyc != H * V) begin
            fails++;
            $display("FAIL bars_valid_cycles: got %0d required %0d", vcyc, H * V);
        end
        push_frame(0, 24'h0);
        wait_valid("bars");
        tick();
        tests++;
        if (last_gap != G) begin
            fails++;
            $display("FAIL bars_gap: got %0d required %0d", last_gap, G);
        end
        enable = 1'b0;
        wait_fd(500, "bars2");
        check_drained("bars");
    endtask

    task automatic test_backpressure();
        pattern_sel = 2'd0;
        push_frame(0, 24'h0);
        rnd_ready = 1'b1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_fd(2000, "bp");
        rnd_ready = 1'b0;
        tready = 1'b1;
        check_drained("bp");
    endtask

    task automatic test_config_change();
        pattern_sel = 2'd1;
        solid_rgb = 24'h0;
        push_frame(1, 24'h0);
        enable = 1'b1;
        wait_beats(20, "cfg");
        pattern_sel = 2'd3;
        solid_rgb = 24'h123456;
        wait_fd(500, "cfg1");
        push_frame(3, 24'h123456);
        wait_valid("cfg");
        enable = 1'b0;
        solid_rgb = 24'hABCDEF;
        wait_fd(500, "cfg2");
        check_drained("cfg");
    endtask

    task automatic test_enable_drop();
        int f0, b0;
        pattern_sel = 2'd0;
        push_frame(0, 24'h0);
        f0 = fd_cnt;
        b0 = beat_cnt;
        enable = 1'b1;
        wait_beats(10, "endrop");
        enable = 1'b0;
        wait_fd(500, "endrop");
        check_drained("endrop");
        tests++;
        if (fd_cnt - f0 != 1 || beat_cnt - b0 != H * V) begin
            fails++;
            $display("FAIL endrop_count: got fd=%0d beats=%0d required 1/%0d",
                     fd_cnt - f0, beat_cnt - b0, H * V);
        end
    endtask

    task automatic test_reset_mid();
        pattern_sel = 2'd0;
        push_frame(0, 24'h0);
        enable = 1'b1;
        wait_beats(30, "rstmid");
        areset = 1'b1;
        tick();
        tests++;
        if (tvalid !== 1'b0 || tdata !== 24'h0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_out: got v%0b d%h b%0b required 0/000000/0",
                     tvalid, tdata, busy);
        end
        exp_q.delete();
        areset = 1'b0;
        push_frame(0, 24'h0);
        tick();
        enable = 1'b0;
        wait_fd(500, "rstmid");
        check_drained("rstmid");
    endtask

    task automatic test_checker();
        int idx, c;
        logic [23:0] e;
        en2 = 1'b1;
        tick();
        en2 = 1'b0;
        idx = 0;
        c = 0;
        while (idx < H2 * V2 && c < 6000) begin
            if (tvalid2) begin
                if (idx == 0 || idx == 31 || idx == 32 ||
                    idx == 32 * H2 || idx == 32 * H2 + 32) begin
                    e = ref_pix(2, idx % H2, idx / H2, 24'h0, H2);
                    tests++;
                    if (tdata2 !== e) begin
                        fails++;
                        $display("FAIL checker(%0d,%0d): got %h required %h",
                                 idx % H2, idx / H2, tdata2, e);
                    end
                end
                idx++;
            end
            tick();
            c++;
        end
        tests++;
        if (idx != H2 * V2) begin
            fails++;
            $display("FAIL checker_len: got %0d required %0d", idx, H2 * V2);
        end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_backpressure();
        test_config_change();
        test_enable_drop();
        test_reset_mid();
        test_checker();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_video_tpg.md
# axis_video_tpg

AXI4-Stream video test-pattern source: generates complete raster frames (24-bit RGB, `tuser` = start-of-frame, `tlast` = end-of-line) on a master port with full backpressure support. Sits upstream of the unsharp filter and other pixel-pipeline stages, replacing the camera/VDMA input for bring-up and regression. Pattern and solid colour are selectable at run time and take effect only at frame boundaries.

## Interface
- `H_ACTIVE`, 640: pixels per line, ≥ 8, multiple of 8.
- `V_ACTIVE`, 480: lines per frame, ≥ 2.
- `FRAME_GAP`, 16: idle cycles between frames (tvalid low), ≥ 0.
- `aclk`  in  1  clock; single clock domain.
- `areset`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request; sampled at frame boundaries.
- `pattern_sel`  in  2  0 colour bars, 1 horizontal ramp, 2 checkerboard, 3 solid.
- `solid_rgb`  in  24  {R,G,B} colour for pattern 3.
- `m_axis_tdata`  out  24  pixel, R in [23:16], G in [15:8], B in [7:0].
- `m_axis_tvalid`  out  1  pixel valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tuser`  out  1  high on pixel (0,0) only.
- `m_axis_tlast`  out  1  high on pixel x = H_ACTIVE-1 of every line.
- `busy`  out  1  high in ACTIVE and GAP.
- `frame_done`  out  1  one-cycle pulse when last pixel of a frame handshakes.

## Operation
- States: IDLE, ACTIVE, GAP.
- IDLE: tvalid=0. When `enable`=1: latch `pattern_sel`, `solid_rgb`; x=y=0; load pixel (0,0); go ACTIVE.
- ACTIVE: present pixel (x,y). On handshake (tvalid & tready): advance x; at x=H_ACTIVE-1 wrap x=0, y++; on last pixel (H_ACTIVE-1, V_ACTIVE-1) pulse `frame_done`, go GAP (or straight to frame restart if FRAME_GAP=0).
- GAP: count FRAME_GAP cycles with tvalid=0, then: `enable`=1 → relatch config, start next frame; else IDLE.
- `enable` deassertion mid-frame never truncates a frame; the frame completes.
- Config changes mid-frame ignored until next latch point.
- Patterns (x,y from counters):
  - Colour bars: 8 bars of width H_ACTIVE/8: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. Bar index from a bar counter, no divider.
  - Ramp: R=G=B=x[7:0] (wraps every 256 pixels).
  - Checkerboard: 32×32 cells; x[5]^y[5] = 0 → FFFFFF, else 000000.
  - Solid: latched `solid_rgb`.
- AXI rules: once tvalid=1, tdata/tuser/tlast held stable until handshake; tvalid never drops without a handshake except via `areset`.

## Timing
- All outputs registered. Reset values: tvalid 0, tdata 0, tuser 0, tlast 0, busy 0, frame_done 0; state IDLE, counters 0.
- `enable` sampled high in IDLE at edge N → tvalid=1 with pixel (0,0) after edge N.
- Throughput 1 pixel/cycle with tready held high; next pixel valid in the cycle after each handshake, no bubbles within a frame, including line wrap.
- Frame with tready=1: exactly H_ACTIVE·V_ACTIVE valid cycles, then FRAME_GAP cycles tvalid=0, then next tuser pixel.
- tready low: all state frozen; gap counter runs only in GAP.
- `frame_done` asserts in the cycle after the final handshake, coincident with entry to GAP.
- `areset` mid-frame: next cycle all outputs at reset values, state IDLE; no partial-frame completion.

## Structure
- Package `vid_pkg`: `pattern_e` enum (BARS, RAMP, CHECKER, SOLID), `tpg_state_e` enum, 24-bit colour constants for the eight bars, pixel width constant 24.
- Sub-module `tpg_pixel_gen`: combinational map (pattern, x, y, bar index, solid colour) → 24-bit RGB; top holds FSM, counters, output registers.

## Test plan
Bench params H_ACTIVE=16, V_ACTIVE=4, FRAME_GAP=3.
- Bars, tready=1, enable=1: 64 beats; tuser only on beat 0; tlast on beats 15,31,47,63; beats 0-1 FFFFFF, 2-3 FFFF00, …, 14-15 000000; then 3 cycles tvalid=0; next frame tuser.
- Random tready (50%): tdata/tuser/tlast stable while tvalid & !tready; captured frame identical to no-backpressure frame.
- Ramp then pattern_sel changed to SOLID (solid_rgb=123456) at beat 20: frame 1 remains ramp (beat k = 0x(k%16) replicated in R, G, B); frame 2 all 123456.
- enable dropped at beat 10: frame completes all 64 beats, `frame_done` single pulse, then IDLE, busy=0.
- areset at beat 30: next cycle tvalid=0, tdata=0; after release with enable=1, restart with tuser on pixel (0,0).
- Checkerboard H_ACTIVE=64, V_ACTIVE=64: pixel (31,0)=FFFFFF, (32,0)=000000, (32,32)=FFFFFF.
